traffic_phase_timer: RTL and testbench

Phase timing stage directly upstream of the traffic light sequencer. It watches the sequencer's current one-hot light code and times how long each phase has been held. When the programmed duration expires, it issues a single-cycle `advance` strobe that steps the sequencer. An optional pedestrian-request path shortens green after a minimum hold and acknowledges the request once red is reached.

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/traffic_phase_timer.sv | 165 ++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Light codes, timer state encoding and phase decode shared
//               with the traffic light sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    // Anything that is not a clean green or yellow code is treated as red.
    function automatic phase_t decode_phase(input logic [2:0] code);
        case (code)
            GREEN:   return PH_GREEN;
            YELLOW:  return PH_YELLOW;
            default: return PH_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider producing a one-cycle tick every
//               TICK_DIV clocks; clr restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + ONE;
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_timer
// Description : Times each light phase and strobes advance on expiry.
//               Optional pedestrian cut of green: TRAFFIC_PED_REQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_timer #(
    parameter int TICK_DIV     = 10,
    parameter int CNT_W        = 8,
    parameter int RED_TICKS    = 30,
    parameter int GREEN_TICKS  = 25,
    parameter int YELLOW_TICKS = 5,
    parameter int GREEN_MIN    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             ped_req,
    output logic             advance,
    output logic             ped_ack,
    output logic [CNT_W-1:0] remaining
);

    import traffic_pkg::*;

    localparam longint        MAX_DUR  = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] RED_D    = CNT_W'(RED_TICKS);
    localparam logic [CNT_W-1:0] GREEN_D  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_D = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if (TICK_DIV < 2) begin : g_chk_div
        $error("TICK_DIV must be at least 2");
    end
    if (RED_TICKS < 1 || RED_TICKS > MAX_DUR) begin : g_chk_red
        $error("RED_TICKS out of range for CNT_W");
    end
    if (GREEN_TICKS < 1 || GREEN_TICKS > MAX_DUR) begin : g_chk_green
        $error("GREEN_TICKS out of range for CNT_W");
    end
    if (YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_DUR) begin : g_chk_yellow
        $error("YELLOW_TICKS out of range for CNT_W");
    end
    if (GREEN_MIN > GREEN_TICKS) begin : g_chk_gmin
        $error("GREEN_MIN must not exceed GREEN_TICKS");
    end

    logic [2:0]       light_q;
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             advance_q, advance_d;
    logic             change;
    logic             tick;
    phase_t           phase;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] cnt_dec;

    assign change = (light != light_q);
    assign phase  = decode_phase(light);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (change),
        .tick (tick)
    );

`ifdef TRAFFIC_PED_REQ_EN
    localparam logic [CNT_W-1:0] GMIN_D = CNT_W'(GREEN_MIN);
    logic pending_q, pending_d;
    logic ack_q,     ack_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        advance_d = 1'b0;
        cnt_dec   = cnt_q - ONE;
        case (phase)
            PH_GREEN:  dur = GREEN_D;
            PH_YELLOW: dur = YELLOW_D;
            default:   dur = RED_D;
        endcase
`ifdef TRAFFIC_PED_REQ_EN
        ack_d     = 1'b0;
        pending_d = pending_q;
        if (ped_req && (phase != PH_RED)) begin
            pending_d = 1'b1;
        end
`endif
        // A phase change always wins over a same-cycle tick.
        if (change) begin
            cnt_d   = dur;
            state_d = RUN;
`ifdef TRAFFIC_PED_REQ_EN
            if ((phase == PH_RED) && pending_q) begin
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end
`endif
        end else if (tick) begin
            case (state_q)
                RUN: begin
                    if (cnt_q == ONE) begin
                        advance_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end else begin
                        cnt_d = cnt_dec;
                    end
`ifdef TRAFFIC_PED_REQ_EN
                    if ((phase == PH_GREEN) && pending_q
                        && ((GREEN_D - cnt_dec) >= GMIN_D)) begin
                        advance_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end
`endif
                end
                WAIT:    advance_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            light_q   <= 3'b000;
            state_q   <= IDLE;
            cnt_q     <= '0;
            advance_q <= 1'b0;
        end else begin
            light_q   <= light;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            advance_q <= advance_d;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end
    assign ped_ack = ack_q;
`else
    assign ped_ack = 1'b0;
`endif

    assign advance   = advance_q;
    assign remaining = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_timer
// Description : Directed self-checking bench; expected strobe cycles are
//               queued when light changes are driven and matched to strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light;
    logic       ped_req;
    logic       advance;
    logic       ped_ack;
    logic [7:0] remaining;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_adv[$];
    int exp_ack[$];
    int obs_adv[64];
    int obs_ack[64];
    int adv_n  = 0;
    int ack_n  = 0;
    int adv_rd = 0;
    int ack_rd = 0;

    traffic_phase_timer #(
        .TICK_DIV     (4),
        .CNT_W        (8),
        .RED_TICKS    (3),
        .GREEN_TICKS  (4),
        .YELLOW_TICKS (2),
        .GREEN_MIN    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .light     (light),
        .ped_req   (ped_req),
        .advance   (advance),
        .ped_ack   (ped_ack),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log the cycle stamp of every strobe seen.
    always @(negedge clk) begin
        if (advance === 1'b1 && adv_n < 64) begin
            obs_adv[adv_n] = cyc;
            adv_n++;
        end
        if (ped_ack === 1'b1 && ack_n < 64) begin
            obs_ack[ack_n] = cyc;
            ack_n++;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_adv(input string tag);
        int e;
        int o;
        #1;
        while (exp_adv.size() > 0) begin
            e = exp_adv.pop_front();
            o = -1;
            if (adv_rd < adv_n) begin
                o = obs_adv[adv_rd];
                adv_rd++;
            end
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s advance_cycle observed=%0d expected=%0d", tag, o, e);
            end
        end
        while (adv_rd < adv_n) begin
            o = obs_adv[adv_rd];
            adv_rd++;
            checks++;
            assert (o === -1) else begin
                failures++;
                $error("FAIL %s unexpected advance observed_cycle=%0d expected=none", tag, o);
            end
        end
    endtask

    task automatic check_ack(input string tag);
        int e;
        int o;
        #1;
        while (exp_ack.size() > 0) begin
            e = exp_ack.pop_front();
            o = -1;
            if (ack_rd < ack_n) begin
                o = obs_ack[ack_rd];
                ack_rd++;
            end
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s ped_ack_cycle observed=%0d expected=%0d", tag, o, e);
            end
        end
        while (ack_rd < ack_n) begin
            o = obs_ack[ack_rd];
            ack_rd++;
            checks++;
            assert (o === -1) else begin
                failures++;
                $error("FAIL %s unexpected ped_ack observed_cycle=%0d expected=none", tag, o);
            end
        end
    endtask

    initial begin
        int l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, a5;
        rst     = 1'b1;
        light   = 3'b100;
        ped_req = 1'b0;
        wait_cyc(3);
        chk("rst_advance", {31'd0, advance}, 32'd0);
        chk("rst_ped_ack", {31'd0, ped_ack}, 32'd0);
        chk("rst_remaining", {24'd0, remaining}, 32'd0);

        // Red from reset: load on the first edge out of reset.
        rst = 1'b0;
        l1  = cyc + 1;
        exp_adv.push_back(l1 + 12);
        wait_cyc(l1);
        chk("red_load", {24'd0, remaining}, 32'd3);
        wait_cyc(l1 + 4);
        chk("red_after_tick1", {24'd0, remaining}, 32'd2);
        wait_cyc(l1 + 12);
        chk("red_end_remaining", {24'd0, remaining}, 32'd0);
        check_adv("red_advance");

        // Green then yellow.
        light = 3'b010;
        l2    = cyc + 1;
        exp_adv.push_back(l2 + 16);
        wait_cyc(l2);
        chk("green_load", {24'd0, remaining}, 32'd4);
        wait_cyc(l2 + 16);
        check_adv("green_advance");
        light = 3'b001;
        l3    = cyc + 1;
        exp_adv.push_back(l3 + 8);
        wait_cyc(l3);
        chk("yellow_load", {24'd0, remaining}, 32'd2);
        wait_cyc(l3 + 8);
        check_adv("yellow_advance");

        // Light held after expiry: strobe repeats every tick.
        exp_adv.push_back(l3 + 12);
        exp_adv.push_back(l3 + 16);
        exp_adv.push_back(l3 + 20);
        wait_cyc(l3 + 14);
        chk("wait_remaining", {24'd0, remaining}, 32'd0);
        wait_cyc(l3 + 20);
        check_adv("wait_repulse");
        light = 3'b100;
        l4    = cyc + 1;
        exp_adv.push_back(l4 + 12);
        wait_cyc(l4);
        chk("red2_load", {24'd0, remaining}, 32'd3);
        wait_cyc(l4 + 12);
        check_adv("red2_advance");
        check_ack("red2_no_ack");

        // Green with a pedestrian pulse around the first tick.
        light = 3'b010;
        l5    = cyc + 1;
        wait_cyc(l5 + 4);
        chk("ped_green_tick1", {24'd0, remaining}, 32'd3);
        ped_req = 1'b1;
        wait_cyc(l5 + 5);
        ped_req = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        a5 = l5 + 8;
`else
        a5 = l5 + 16;
`endif
        exp_adv.push_back(a5);
        wait_cyc(a5);
        chk("ped_green_remaining", {24'd0, remaining}, 32'd0);
        check_adv("ped_green_advance");
        light = 3'b001;
        l6    = cyc + 1;
        exp_adv.push_back(l6 + 8);
        wait_cyc(l6 + 8);
        check_adv("ped_yellow_advance");
        light = 3'b100;
        l7    = cyc + 1;
`ifdef TRAFFIC_PED_REQ_EN
        exp_ack.push_back(l7);
`endif
        exp_adv.push_back(l7 + 12);
        wait_cyc(l7 + 1);
        check_ack("ped_ack_red");
        wait_cyc(l7 + 12);
        check_adv("ped_red_advance");

        // Reset mid-green, then a full green restart.
        light = 3'b010;
        l8    = cyc + 1;
        wait_cyc(l8 + 9);
        chk("midgreen_remaining", {24'd0, remaining}, 32'd2);
        rst = 1'b1;
        wait_cyc(l8 + 10);
        chk("midrst_advance", {31'd0, advance}, 32'd0);
        chk("midrst_ped_ack", {31'd0, ped_ack}, 32'd0);
        chk("midrst_remaining", {24'd0, remaining}, 32'd0);
        rst = 1'b0;
        l9  = cyc + 1;
        exp_adv.push_back(l9 + 16);
        wait_cyc(l9);
        chk("restart_green_load", {24'd0, remaining}, 32'd4);
        wait_cyc(l9 + 16);
        check_adv("restart_green_advance");

        // Invalid code is timed as red; pedestrian toggling has no effect.
        light = 3'b011;
        l10   = cyc + 1;
        exp_adv.push_back(l10 + 12);
        wait_cyc(l10);
        chk("invalid_load", {24'd0, remaining}, 32'd3);
        for (int i = 0; i < 12; i++) begin
            ped_req = ~ped_req;
            @(negedge clk);
        end
        ped_req = 1'b0;
        chk("invalid_end_remaining", {24'd0, remaining}, 32'd0);
        check_adv("invalid_advance");
        check_ack("invalid_no_ack");

        wait_cyc(cyc + 2);
        check_adv("final_advance");
        check_ack("final_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
